// File: rtl/dbg_bus_master_if.sv
// -----------------------------------------------------------------------------
// dbg_bus_master_if
// Groups the byte streams and the debug data-bus master signals of the debug
// command engine.
//   rx_data/rx_valid/rx_ready   command byte stream from the UART receiver
//   tx_data/tx_valid/tx_ready   response byte stream to the UART transmitter
//   ds_cpu_halt                 CPU halt request (debug side owns the bus while 1)
//   dbg_address/dbg_write_data  bus address / write data
//   dbg_reqw/dbg_mode/dbg_reqs  access width, access mode, sign-extend request
//   dbg_read_data               combinational read data returned by the bus
// modport master: the engine side; modport slave: UART + bus/arbiter side.
// -----------------------------------------------------------------------------
interface dbg_bus_master_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        ds_cpu_halt;
    logic [31:0] dbg_address;
    logic [31:0] dbg_write_data;
    logic [1:0]  dbg_reqw;
    logic [1:0]  dbg_mode;
    logic        dbg_reqs;
    logic [31:0] dbg_read_data;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready,
        output tx_data, tx_valid,
        input  tx_ready,
        output ds_cpu_halt, dbg_address, dbg_write_data, dbg_reqw, dbg_mode, dbg_reqs,
        input  dbg_read_data
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready,
        input  tx_data, tx_valid,
        output tx_ready,
        input  ds_cpu_halt, dbg_address, dbg_write_data, dbg_reqw, dbg_mode, dbg_reqs,
        output dbg_read_data
    );
endinterface

// File: rtl/dbg_bus_master.sv
// -----------------------------------------------------------------------------
// dbg_bus_master
// Debug-port command engine: turns command bytes from the debug UART into
// single-word transactions on the debug bus master port and returns response
// bytes on the transmit stream.
//
// Ports:
//   clk      system clock, rising edge
//   reset_n  synchronous, active-low reset
//   bus      dbg_bus_master_if.master (rx/tx byte streams, halt, dbg_* bus)
//
// Commands: 0x01 HALT, 0x02 RESUME, 0x03 WRITE addr[4] data[4],
//           0x04 READ addr[4]; anything else replies 0xEE.
// Optional feature macro FEATURE_DBG_AUTOINC_EN adds 0x05 READ_NEXT and
// 0x06 WRITE_NEXT data[4], both accessing the stored address + 4.
// -----------------------------------------------------------------------------
module dbg_bus_master (
    input  logic             clk,
    input  logic             reset_n,
    dbg_bus_master_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_BUS,
        S_RESP
    } state_t;

    // Response descriptor: either a single status code or the 4 read bytes.
    typedef struct packed {
        logic       rd4;
        logic [7:0] code;
    } resp_t;

    localparam logic [7:0] CMD_HALT   = 8'h01;
    localparam logic [7:0] CMD_RESUME = 8'h02;
    localparam logic [7:0] CMD_WRITE  = 8'h03;
    localparam logic [7:0] CMD_READ   = 8'h04;
`ifdef FEATURE_DBG_AUTOINC_EN
    localparam logic [7:0] CMD_RDNEXT = 8'h05;
    localparam logic [7:0] CMD_WRNEXT = 8'h06;
`endif
    localparam logic [7:0] RSP_ACK    = 8'hAA;
    localparam logic [7:0] RSP_NAK    = 8'hEE;

    localparam logic [1:0] MODE_IDLE  = 2'b00;
    localparam logic [1:0] MODE_READ  = 2'b01;
    localparam logic [1:0] MODE_WRITE = 2'b10;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        is_wr_q, is_wr_d;
    logic        halt_q, halt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    resp_t       resp_q, resp_d;

    logic        rx_ready;
    logic        tx_valid;
    logic [1:0]  mode;
    logic [4:0]  byte_sel;

    // Little-endian byte lane selected by the shared byte counter.
    assign byte_sel = {cnt_q, 3'b000};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            is_wr_q <= 1'b0;
            halt_q  <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            is_wr_q <= is_wr_d;
            halt_q  <= halt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            resp_q  <= resp_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_wr_d  = is_wr_q;
        halt_d   = halt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        resp_d   = resp_q;
        rx_ready = 1'b0;
        tx_valid = 1'b0;
        mode     = MODE_IDLE;

        unique case (state_q)
            S_IDLE: begin
                rx_ready = 1'b1;
                if (bus.rx_valid) begin
                    cnt_d  = 2'd0;
                    resp_d = '{rd4: 1'b0, code: RSP_ACK};
                    case (bus.rx_data)
                        CMD_HALT: begin
                            halt_d  = 1'b1;
                            state_d = S_RESP;
                        end
                        CMD_RESUME: begin
                            halt_d  = 1'b0;
                            state_d = S_RESP;
                        end
                        CMD_WRITE: begin
                            is_wr_d = 1'b1;
                            state_d = S_ADDR;
                        end
                        CMD_READ: begin
                            is_wr_d = 1'b0;
                            state_d = S_ADDR;
                        end
`ifdef FEATURE_DBG_AUTOINC_EN
                        // The halt state cannot change while a command is in
                        // flight, so the increment can be decided up front.
                        CMD_RDNEXT: begin
                            is_wr_d = 1'b0;
                            state_d = S_BUS;
                            if (halt_q) addr_d = addr_q + 32'd4;
                        end
                        CMD_WRNEXT: begin
                            is_wr_d = 1'b1;
                            state_d = S_DATA;
                            if (halt_q) addr_d = addr_q + 32'd4;
                        end
`endif
                        default: begin
                            resp_d  = '{rd4: 1'b0, code: RSP_NAK};
                            state_d = S_RESP;
                        end
                    endcase
                end
            end

            S_ADDR: begin
                rx_ready = 1'b1;
                if (bus.rx_valid) begin
                    addr_d[byte_sel +: 8] = bus.rx_data;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = is_wr_q ? S_DATA : S_BUS;
                end
            end

            S_DATA: begin
                rx_ready = 1'b1;
                if (bus.rx_valid) begin
                    wdata_d[byte_sel +: 8] = bus.rx_data;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = S_BUS;
                end
            end

            // One cycle; the access is only driven when the CPU is halted,
            // otherwise the slot is kept so the reply latency is identical.
            S_BUS: begin
                cnt_d   = 2'd0;
                state_d = S_RESP;
                if (halt_q) begin
                    mode   = is_wr_q ? MODE_WRITE : MODE_READ;
                    resp_d = '{rd4: !is_wr_q, code: RSP_ACK};
                    if (!is_wr_q) rdata_d = bus.dbg_read_data;
                end else begin
                    resp_d = '{rd4: 1'b0, code: RSP_NAK};
                end
            end

            S_RESP: begin
                tx_valid = 1'b1;
                if (bus.tx_ready) begin
                    if (!resp_q.rd4 || cnt_q == 2'd3) begin
                        cnt_d   = 2'd0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.rx_ready       = rx_ready;
    assign bus.tx_valid       = tx_valid;
    assign bus.tx_data        = (state_q != S_RESP) ? 8'h00 :
                                resp_q.rd4 ? rdata_q[byte_sel +: 8] : resp_q.code;
    assign bus.ds_cpu_halt    = halt_q;
    assign bus.dbg_address    = addr_q;
    assign bus.dbg_write_data = wdata_q;
    assign bus.dbg_mode       = mode;
    assign bus.dbg_reqw       = 2'b10;
    assign bus.dbg_reqs       = 1'b0;

endmodule

// File: tb/tb_dbg_bus_master.sv
module tb_dbg_bus_master;

    typedef struct packed {
        logic [1:0]  mode;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_t;

    logic        clk;
    logic        reset_n;
    logic [31:0] rd_value;
    logic        tx_toggle;

    int checks;
    int errors;

    logic [7:0] exp_tx[$];
    bus_t       exp_bus[$];

    dbg_bus_master_if bif();

    dbg_bus_master dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bif.master)
    );

    // Read data only meaningful during a read access; garbage otherwise.
    assign bif.dbg_read_data = (bif.dbg_mode == 2'b01) ? rd_value : 32'hBAD0_BAD0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rx_ready"}, {31'd0, bif.rx_ready}, 32'd1);
        chk({tag, "_tx_valid"}, {31'd0, bif.tx_valid}, 32'd0);
        chk({tag, "_tx_data"}, {24'd0, bif.tx_data}, 32'h0);
        chk({tag, "_halt"}, {31'd0, bif.ds_cpu_halt}, 32'd0);
        chk({tag, "_addr"}, bif.dbg_address, 32'h0);
        chk({tag, "_wdata"}, bif.dbg_write_data, 32'h0);
        chk({tag, "_mode"}, {30'd0, bif.dbg_mode}, 32'd0);
        chk({tag, "_reqw"}, {30'd0, bif.dbg_reqw}, 32'd2);
        chk({tag, "_reqs"}, {31'd0, bif.dbg_reqs}, 32'd0);
    endtask

    // Present one byte and hold it until accepted; returns 1 ns after the
    // accepting edge.
    task automatic send(input logic [7:0] b);
        bit ok = 1'b0;
        bif.rx_data  = b;
        bif.rx_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bif.rx_ready) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        bif.rx_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL rx_timeout: byte %h not accepted, expected acceptance", b);
        end
    endtask

    task automatic send_seq(input logic [7:0] b[]);
        foreach (b[i]) send(b[i]);
    endtask

    // Wait until every expected reply byte has been consumed and tx is idle.
    task automatic wait_done(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (exp_tx.size() == 0 && !bif.tx_valid) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d reply bytes outstanding, expected 0", name, exp_tx.size());
        end
    endtask

    initial begin
        logic [7:0] e;
        bus_t       eb;
        bit         hold_q;
        logic [7:0] hold_data;

        checks       = 0;
        errors       = 0;
        reset_n      = 1'b0;
        rd_value     = 32'h0;
        tx_toggle    = 1'b0;
        bif.rx_data  = 8'h00;
        bif.rx_valid = 1'b0;
        bif.tx_ready = 1'b1;
        hold_q       = 1'b0;
        hold_data    = 8'h00;

        fork
            // Scoreboard monitor: tx bytes and bus cycles.
            forever begin
                @(negedge clk);
                if (reset_n) begin
                    if (hold_q) begin
                        chk("tx_hold_valid", {31'd0, bif.tx_valid}, 32'd1);
                        chk("tx_hold_data", {24'd0, bif.tx_data}, {24'd0, hold_data});
                    end
                    hold_q    = bif.tx_valid && !bif.tx_ready;
                    hold_data = bif.tx_data;
                    if (bif.tx_valid && bif.tx_ready) begin
                        if (exp_tx.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL tx_unexpected: got %h expected no byte", bif.tx_data);
                        end else begin
                            e = exp_tx.pop_front();
                            chk("tx_byte", {24'd0, bif.tx_data}, {24'd0, e});
                        end
                    end
                    if (bif.dbg_mode != 2'b00) begin
                        if (exp_bus.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL bus_unexpected: got mode %b addr %h expected idle",
                                     bif.dbg_mode, bif.dbg_address);
                        end else begin
                            eb = exp_bus.pop_front();
                            chk("bus_mode", {30'd0, bif.dbg_mode}, {30'd0, eb.mode});
                            chk("bus_addr", bif.dbg_address, eb.addr);
                            chk("bus_reqw", {30'd0, bif.dbg_reqw}, 32'd2);
                            if (eb.mode == 2'b10) chk("bus_wdata", bif.dbg_write_data, eb.wdata);
                        end
                    end
                end else begin
                    hold_q = 1'b0;
                end
            end
            // Transmitter ready: always 1, or toggling every cycle.
            forever begin
                @(posedge clk);
                #1;
                bif.tx_ready = tx_toggle ? ~bif.tx_ready : 1'b1;
            end
        join_none

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // HALT / RESUME
        exp_tx.push_back(8'hAA);
        send(8'h01);
        chk("halt_set", {31'd0, bif.ds_cpu_halt}, 32'd1);
        chk("halt_lat_txv", {31'd0, bif.tx_valid}, 32'd1);
        wait_done("halt");
        exp_tx.push_back(8'hAA);
        send(8'h02);
        chk("resume_clr", {31'd0, bif.ds_cpu_halt}, 32'd0);
        wait_done("resume");

        // Halted WRITE
        exp_tx.push_back(8'hAA);
        send(8'h01);
        wait_done("halt2");
        exp_bus.push_back('{mode: 2'b10, addr: 32'h0000_3000, wdata: 32'hDEAD_BEEF});
        exp_tx.push_back(8'hAA);
        send_seq('{8'h03, 8'h00, 8'h30, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE});
        chk("wr_bus_cycle_mode", {30'd0, bif.dbg_mode}, 32'd2);
        chk("wr_bus_cycle_txv", {31'd0, bif.tx_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("wr_after_bus_mode", {30'd0, bif.dbg_mode}, 32'd0);
        chk("wr_resp_txv", {31'd0, bif.tx_valid}, 32'd1);
        wait_done("write");

        // Halted READ with tx_ready toggling
        rd_value  = 32'h1234_5678;
        tx_toggle = 1'b1;
        exp_bus.push_back('{mode: 2'b01, addr: 32'h0000_40F0, wdata: 32'h0});
        exp_tx.push_back(8'h78);
        exp_tx.push_back(8'h56);
        exp_tx.push_back(8'h34);
        exp_tx.push_back(8'h12);
        send_seq('{8'h04, 8'hF0, 8'h40, 8'h00, 8'h00});
        wait_done("read");
        tx_toggle = 1'b0;
        @(posedge clk);
        #1;

        // Not halted: READ / WRITE rejected, unknown command
        exp_tx.push_back(8'hAA);
        send(8'h02);
        wait_done("resume2");
        exp_tx.push_back(8'hEE);
        send_seq('{8'h04, 8'h11, 8'h22, 8'h33, 8'h44});
        wait_done("read_nohalt");
        exp_tx.push_back(8'hEE);
        send_seq('{8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08});
        wait_done("write_nohalt");
        exp_tx.push_back(8'hEE);
        send(8'h7F);
        wait_done("unknown");

        // Reset in the middle of a halted WRITE
        exp_tx.push_back(8'hAA);
        send(8'h01);
        wait_done("halt3");
        send_seq('{8'h03, 8'h00, 8'h30});
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_vals("midrst");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        exp_tx.push_back(8'hAA);
        send(8'h01);
        chk("halt_after_rst", {31'd0, bif.ds_cpu_halt}, 32'd1);
        wait_done("halt4");

`ifdef FEATURE_DBG_AUTOINC_EN
        // Stored address wraps on READ_NEXT
        rd_value = 32'hA1B2_C3D4;
        exp_bus.push_back('{mode: 2'b01, addr: 32'hFFFF_FFFC, wdata: 32'h0});
        exp_tx.push_back(8'hD4);
        exp_tx.push_back(8'hC3);
        exp_tx.push_back(8'hB2);
        exp_tx.push_back(8'hA1);
        send_seq('{8'h04, 8'hFC, 8'hFF, 8'hFF, 8'hFF});
        wait_done("read_top");
        exp_bus.push_back('{mode: 2'b01, addr: 32'h0000_0000, wdata: 32'h0});
        exp_tx.push_back(8'hD4);
        exp_tx.push_back(8'hC3);
        exp_tx.push_back(8'hB2);
        exp_tx.push_back(8'hA1);
        send(8'h05);
        wait_done("read_next");
`else
        // Without the feature, 0x05/0x06 are unknown and consume no arguments
        exp_tx.push_back(8'hEE);
        send(8'h05);
        wait_done("rdnext_unknown");
        exp_tx.push_back(8'hEE);
        send(8'h06);
        wait_done("wrnext_unknown");
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("tx_queue_drained", exp_tx.size(), 32'd0);
        chk("bus_queue_drained", exp_bus.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
